// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and channel-index width helper for clk_div_multi
package clk_div_pkg;
    localparam int DIV_WIDTH_DEF   = 26;
    localparam int NCH_DEF         = 4;
    localparam int DEFAULT_DIV_DEF = 2000000;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadowed divisor applied at half-period boundaries
module clk_div_ch import clk_div_pkg::*; #(
    parameter int WIDTH       = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    logic [WIDTH-1:0] cnt, act_div, shd_div;
    logic bnd, hold, apply;
    always_comb begin
        bnd   = en && (cnt >= act_div);
        hold  = sync_clr || !en;
        apply = hold || bnd;
    end
    // a write landing on a boundary stays pending: pending is sampled before wr sets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act_div <= WIDTH'(DEFAULT_DIV);
            shd_div <= WIDTH'(DEFAULT_DIV);
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= apply ? '0 : cnt + 1'b1;
            clk_out <= hold ? 1'b0 : clk_out ^ bnd;
            tick    <= !hold && bnd && !clk_out;
            if (apply && pending) act_div <= shd_div;
            if (wr) shd_div <= wdata;
            pending <= wr || (pending && !apply);
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent clock dividers sharing one clock, config port and sync clear
module clk_div_multi import clk_div_pkg::*; #(
    parameter int WIDTH       = DIV_WIDTH_DEF,
    parameter int NCH         = NCH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          en,
    input  logic                    sync_clr,
    input  logic                    cfg_wr,
    input  logic [ch_w(NCH)-1:0]    cfg_ch,
    input  logic [WIDTH-1:0]        cfg_div,
    output logic [NCH-1:0]          clk_out,
    output logic [NCH-1:0]          tick,
    output logic [NCH-1:0]          cfg_pending
);
    localparam int CW = ch_w(NCH);
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_ch #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync_clr(sync_clr),
            .wr      (cfg_wr && (cfg_ch == CW'(g))),
            .wdata   (cfg_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (cfg_pending[g])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scenario tasks plus a tick scoreboard checked every cycle on the falling edge
module tb_clk_div_multi;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int DDIV  = 3;

    typedef struct { int cyc; int ch; } ev_t;

    logic             clk, rst_n, sync_clr, cfg_wr;
    logic [NCH-1:0]   en, clk_out, tick, cfg_pending, mon_en;
    logic [1:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    int               cyc = 0, errors = 0, checks = 0;
    ev_t              sb[$];
    bit               hit;

    clk_div_multi #(.WIDTH(WIDTH), .NCH(NCH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .cfg_wr(cfg_wr),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick),
        .cfg_pending(cfg_pending)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: expected (cycle, channel) tick events, sorted by cycle then channel
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL sb_missed: ch%0d tick missing at cycle %0d", sb[0].ch, sb[0].cyc);
            void'(sb.pop_front());
        end
        for (int i = 0; i < NCH; i++) begin
            hit = sb.size() > 0 && sb[0].cyc == cyc && sb[0].ch == i;
            if (mon_en[i] && (tick[i] || hit)) begin
                checks++;
                if (tick[i] !== hit || (hit && clk_out[i] !== 1'b1)) begin
                    errors++;
                    $display("FAIL sb_tick: ch%0d cycle %0d tick=%b clk_out=%b, required tick=%b clk_out=1",
                             i, cyc, tick[i], clk_out[i], hit);
                end
                if (hit) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input int ch);
        sb.push_back('{c, ch});
    endtask

    task automatic stop_all(output int b);
        en = '0;
        step();
        b = cyc;
    endtask

    task automatic test_reset;
        rst_n = 0; en = '0; sync_clr = 0; cfg_wr = 0; cfg_ch = '0; cfg_div = '0; mon_en = '0;
        step(3);
        checks++;
        if (clk_out !== '0) begin errors++; $display("FAIL reset_clk_out: got %b, required 0000", clk_out); end
        checks++;
        if (tick !== '0) begin errors++; $display("FAIL reset_tick: got %b, required 0000", tick); end
        checks++;
        if (cfg_pending !== '0) begin errors++; $display("FAIL reset_pending: got %b, required 0000", cfg_pending); end
        rst_n = 1;
        step();
    endtask

    task automatic test_basic;
        int c, hi;
        logic [NCH-1:0] other;
        c = cyc; hi = 0; other = '0;
        mon_en = '1;
        en = 4'b0001;
        for (int k = 0; k < 4; k++) push(c + 4 + 8 * k, 0);
        for (int k = 0; k < 32; k++) begin
            step();
            hi += int'(clk_out[0]);
            other |= clk_out & 4'b1110;
        end
        checks++;
        if (hi !== 16) begin errors++; $display("FAIL basic_duty: high cycles %0d of 32, required 16", hi); end
        checks++;
        if (other !== '0) begin errors++; $display("FAIL basic_others: clk_out[3:1] seen %b, required 000", other[3:1]); end
    endtask

    task automatic test_reconfig;
        int b;
        stop_all(b);
        en = 4'b0001;
        push(b + 4, 0); push(b + 8, 0); push(b + 12, 0);
        step();
        cfg_wr = 1; cfg_ch = 2'd0; cfg_div = 8'd1;
        step();
        cfg_wr = 0;
        checks++;
        if (cfg_pending[0] !== 1'b1) begin errors++; $display("FAIL reconfig_pending_set: got %b, required 1", cfg_pending[0]); end
        step();
        checks++;
        if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL reconfig_old_half: clk_out[0]=%b at cycle 3, required 0", clk_out[0]); end
        step();
        checks++;
        if (cfg_pending[0] !== 1'b0) begin errors++; $display("FAIL reconfig_pending_clr: got %b, required 0", cfg_pending[0]); end
        step(2);
        checks++;
        if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL reconfig_short_half: clk_out[0]=%b at cycle 6, required 0", clk_out[0]); end
        step(7);
    endtask

    task automatic test_last_wins;
        int b;
        stop_all(b);
        en = 4'b0010;
        push(b + 4, 1); push(b + 10, 1); push(b + 16, 1);
        step();
        cfg_wr = 1; cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        cfg_div = 8'd2;
        step();
        cfg_wr = 0;
        checks++;
        if (cfg_pending[1] !== 1'b1) begin errors++; $display("FAIL lastwins_pending_set: got %b, required 1", cfg_pending[1]); end
        step();
        checks++;
        if (cfg_pending[1] !== 1'b0) begin errors++; $display("FAIL lastwins_pending_clr: got %b, required 0", cfg_pending[1]); end
        step(13);
    endtask

    task automatic test_boundary_write;
        int b;
        stop_all(b);
        en = 4'b1000;
        push(b + 4, 3); push(b + 10, 3); push(b + 14, 3);
        step(3);
        cfg_wr = 1; cfg_ch = 2'd3; cfg_div = 8'd1;
        step();
        cfg_wr = 0;
        checks++;
        if (cfg_pending[3] !== 1'b1) begin errors++; $display("FAIL bndwr_pending_kept: got %b, required 1", cfg_pending[3]); end
        step(3);
        checks++;
        if (clk_out[3] !== 1'b1) begin errors++; $display("FAIL bndwr_old_half: clk_out[3]=%b at cycle 7, required 1", clk_out[3]); end
        step();
        checks++;
        if (cfg_pending[3] !== 1'b0) begin errors++; $display("FAIL bndwr_pending_clr: got %b, required 0", cfg_pending[3]); end
        step(7);
    endtask

    task automatic test_sync;
        int a;
        mon_en = '0;
        en = '0;
        cfg_wr = 1; cfg_ch = 2'd0; cfg_div = 8'd3;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        cfg_wr = 0;
        step();
        a = cyc;
        en = 4'b0001;
        step(2);
        en = 4'b0011;
        step(3);
        checks++;
        if (clk_out[0] !== 1'b1) begin errors++; $display("FAIL sync_pre: clk_out[0]=%b before clear, required 1", clk_out[0]); end
        sync_clr = 1;
        mon_en = '1;
        push(a + 10, 0); push(a + 12, 1); push(a + 18, 0); push(a + 24, 1);
        step();
        sync_clr = 0;
        checks++;
        if (clk_out[1:0] !== 2'b00) begin errors++; $display("FAIL sync_clk_out: got %b, required 00", clk_out[1:0]); end
        checks++;
        if (tick !== '0) begin errors++; $display("FAIL sync_tick: got %b, required 0000", tick); end
        step(19);
    endtask

    task automatic test_enable;
        int b;
        stop_all(b);
        en = 4'b0100;
        push(b + 4, 2); push(b + 11, 2);
        step(5);
        checks++;
        if (clk_out[2] !== 1'b1) begin errors++; $display("FAIL enable_pre: clk_out[2]=%b, required 1", clk_out[2]); end
        en = '0;
        step();
        checks++;
        if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL enable_drop: clk_out[2]=%b, required 0", clk_out[2]); end
        step();
        en = 4'b0100;
        step(3);
        checks++;
        if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL enable_early: clk_out[2]=%b before act_div+1, required 0", clk_out[2]); end
        step(2);
    endtask

    task automatic test_reset_mid;
        int b, r;
        stop_all(b);
        mon_en = '0;
        en = 4'b0001;
        step(5);
        cfg_wr = 1; cfg_ch = 2'd0; cfg_div = 8'd1;
        step();
        cfg_wr = 0;
        checks++;
        if (clk_out[0] !== 1'b1 || cfg_pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: clk_out[0]=%b pending[0]=%b, required 1 1", clk_out[0], cfg_pending[0]);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (clk_out !== '0 || tick !== '0 || cfg_pending !== '0) begin
            errors++;
            $display("FAIL rstmid_async: clk_out=%b tick=%b pending=%b, required all 0", clk_out, tick, cfg_pending);
        end
        step(2);
        rst_n = 1;
        r = cyc;
        mon_en = '1;
        push(r + 4, 0); push(r + 12, 0);
        step();
        checks++;
        if (cfg_pending !== '0) begin errors++; $display("FAIL rstmid_pending: got %b, required 0000", cfg_pending); end
        step(2);
        checks++;
        if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL rstmid_default_div: clk_out[0]=%b at cycle 3, required 0", clk_out[0]); end
        step(10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_last_wins();
        test_boundary_write();
        test_sync();
        test_enable();
        test_reset_mid();
        en = '0;
        step(2);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d events, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
